// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction fetch stage of the 5-stage MIPS pipeline.
//
// Holds the PC and a word-addressed instruction memory that is loaded while
// idle, then fetches one word per cycle for the IF/ID latch. A three-state
// control FSM (IDLE -> RUN -> HALTED) sequences program load, run and halt.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset (imem is not cleared)
//   load_en        write load_data into imem (IDLE only)
//   load_addr      byte address of the load write, bits [1:0] ignored
//   load_data      instruction word to write
//   run            start execution from PC 0 (IDLE only)
//   stall          hazard unit request to hold the PC this cycle
//   branch_taken   redirect to branch_target (highest priority)
//   branch_target  branch destination byte address
//   jump           redirect to jump_target
//   jump_target    jump destination byte address
//   step           (IF_STEP_EN only) allow sequential advance this cycle
//   pc_out         current PC
//   next_pc_out    pc_out + 4 (mod 2^32)
//   instr_out      fetched instruction, 0 (NOP) outside RUN
//   halted         high while in HALTED
//
// Optional feature macro: IF_STEP_EN adds the step input; without step=1 the
// stage injects bubbles instead of advancing, while still accepting redirects.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        run,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
`ifdef IF_STEP_EN
    input  logic        step,
`endif
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] instr_out,
    output logic        halted
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   imem [IMEM_DEPTH];

    logic          load_in_range;
    logic          pc_in_range;
    logic [AW-1:0] load_idx;
    logic [AW-1:0] pc_idx;
    logic [31:0]   fetch_word;
    logic          fetch_en;
    logic          unused_bits;

    // Any address bit at or above the memory size puts the access out of range.
    assign load_in_range = (load_addr >> (AW + 2)) == 32'd0;
    assign pc_in_range   = (pc_q >> (AW + 2)) == 32'd0;
    assign load_idx      = load_addr[AW+1:2];
    assign pc_idx        = pc_q[AW+1:2];
    assign fetch_word    = pc_in_range ? imem[pc_idx] : 32'd0;

`ifdef IF_STEP_EN
    assign fetch_en = step;
`else
    assign fetch_en = 1'b1;
`endif

    // Byte-offset bits of the addresses carry no information.
    assign unused_bits = ^{load_addr[1:0], branch_target[1:0], jump_target[1:0]};

    assign pc_out      = pc_q;
    assign next_pc_out = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_out = 32'd0;
        halted    = 1'b0;
        case (state_q)
            StIdle: begin
                pc_d = 32'd0;
                if (run) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                instr_out = fetch_en ? fetch_word : 32'd0;
                if (branch_taken) begin
                    pc_d = {branch_target[31:2], 2'b00};
                end else if (jump) begin
                    pc_d = {jump_target[31:2], 2'b00};
                end else if (stall || !fetch_en) begin
                    pc_d = pc_q;
                end else if (fetch_word == HALT_WORD) begin
                    // Halt word is only honoured on the correct path, so a
                    // redirect above takes precedence.
                    state_d = StHalted;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
                pc_d    = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Program memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (!reset && state_q == StIdle && load_en && load_in_range) begin
            imem[load_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: self-checking bench for if_stage.
// A table of per-cycle stimulus rows with the outputs expected during that
// cycle; expected values go into a scoreboard queue when a row is driven and
// are popped and compared once the outputs have settled.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, load_en, run, stall, branch_taken, jump, step;
    logic [31:0] load_addr, load_data, branch_target, jump_target;
    logic [31:0] pc_out, next_pc_out, instr_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage #(
        .IMEM_DEPTH(256),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .run          (run),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
`ifdef IF_STEP_EN
        .step         (step),
`endif
        .pc_out       (pc_out),
        .next_pc_out  (next_pc_out),
        .instr_out    (instr_out),
        .halted       (halted)
    );

    typedef struct {
        logic        rst;
        logic        ld;
        logic [31:0] la;
        logic [31:0] ldat;
        logic        run;
        logic        st;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        chk;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        ehalt;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] instr;
        logic        halt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic ld, input logic [31:0] la,
                                input logic [31:0] ldat, input logic rn, input logic st,
                                input logic br, input logic [31:0] bt, input logic jp,
                                input logic [31:0] jt, input logic chk,
                                input logic [31:0] epc, input logic [31:0] ei,
                                input logic eh);
        vec_t v;
        v.rst = rst; v.ld = ld; v.la = la; v.ldat = ldat; v.run = rn; v.st = st;
        v.br = br; v.bt = bt; v.jp = jp; v.jt = jt; v.chk = chk;
        v.epc = epc; v.einstr = ei; v.ehalt = eh;
        return v;
    endfunction

    // Idle row with an optional load and run; outputs must show the idle state.
    function automatic vec_t idle(input logic ld, input logic [31:0] la,
                                  input logic [31:0] ldat, input logic rn);
        return mk(1'b0, ld, la, ldat, rn, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0, 0, 1'b0);
    endfunction

    // Running row: control inputs plus the PC/instruction expected this cycle.
    function automatic vec_t rv(input logic st, input logic br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt,
                                input logic [31:0] epc, input logic [31:0] ei);
        return mk(1'b0, 1'b0, 0, 0, 1'b0, st, br, bt, jp, jt, 1'b1, epc, ei, 1'b0);
    endfunction

    task automatic cmp(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        exp_t e;
        @(negedge clk);
        reset = v.rst; load_en = v.ld; load_addr = v.la; load_data = v.ldat;
        run = v.run; stall = v.st; branch_taken = v.br; branch_target = v.bt;
        jump = v.jp; jump_target = v.jt;
        if (v.chk) begin
            e.row = row; e.pc = v.epc; e.npc = v.epc + 32'd4;
            e.instr = v.einstr; e.halt = v.ehalt;
            sb.push_back(e);
        end
        #1;
        if (v.chk) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard row %0d: got empty queue, expected entry", row);
            end else begin
                e = sb.pop_front();
                cmp("pc_out", e.row, pc_out, e.pc);
                cmp("next_pc_out", e.row, next_pc_out, e.npc);
                cmp("instr_out", e.row, instr_out, e.instr);
                cmp("halted", e.row, {31'd0, halted}, {31'd0, e.halt});
            end
        end
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; run = 1'b0; stall = 1'b0; step = 1'b1;
        branch_taken = 1'b0; jump = 1'b0;
        load_addr = 0; load_data = 0; branch_target = 0; jump_target = 0;

        // Reset, then program load (including one out-of-range write).
        vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_0000, 32'h2001_0005, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_0004, 32'h2002_0007, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_000C, 32'h3333_3333, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_0011, 32'h2003_000A, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_0040, 32'h1111_1111, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_0080, 32'h2222_2222, 1'b0));
        vecs.push_back(idle(1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0));
        // Load and run together: the write lands, then RUN starts.
        vecs.push_back(idle(1'b1, 32'h0000_0014, 32'h2004_0004, 1'b1));

        // Scenario 1; load/run during RUN must be ignored.
        vecs.push_back(mk(1'b0, 1'b1, 0, 32'hBAD0_BAD0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0,
                          1'b1, 32'h0, 32'h2001_0005, 1'b0));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h4, 32'h2002_0007));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h8, 32'hFFFF_FFFF));
        for (int i = 0; i < 11; i++) begin
            vecs.push_back(mk(1'b0, 1'b1, 0, 32'hBAD1_BAD1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0,
                              1'b1, 32'h8, 32'h0, 1'b1));
        end
        // Reset while HALTED, then stall / priority / misaligned redirect.
        vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0,
                          1'b1, 32'h8, 32'h0, 1'b1));
        vecs.push_back(idle(1'b0, 0, 0, 1'b1));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 32'h2001_0005));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(rv(1'b1, 1'b0, 0, 1'b0, 0, 32'h4, 32'h2002_0007));
        end
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h4, 32'h2002_0007));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b1, 32'h13, 32'h8, 32'hFFFF_FFFF));
        vecs.push_back(rv(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 32'h10, 32'h2003_000A));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b1, 32'h0C, 32'h40, 32'h1111_1111));
        // Reset mid-RUN at 0x0C, then re-run reproduces scenario 1.
        vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0,
                          1'b1, 32'h0C, 32'h3333_3333, 1'b0));
        vecs.push_back(idle(1'b0, 0, 0, 1'b1));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 32'h2001_0005));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h4, 32'h2002_0007));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h8, 32'hFFFF_FFFF));
        vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0,
                          1'b1, 32'h8, 32'h0, 1'b1));
        // Out-of-range fetch, misaligned branch, PC wrap at the top of memory.
        vecs.push_back(idle(1'b0, 0, 0, 1'b1));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b1, 32'h1000, 32'h0, 32'h2001_0005));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h1000, 32'h0));
        vecs.push_back(rv(1'b0, 1'b1, 32'h17, 1'b0, 0, 32'h1004, 32'h0));
        vecs.push_back(rv(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0, 32'h14, 32'h2004_0004));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'hFFFF_FFFC, 32'h0));
        vecs.push_back(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 32'h2001_0005));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

`ifdef IF_STEP_EN
        // PC is now 4: bubbles while step=0, then advance on step pulses.
        step = 1'b0;
        apply(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h4, 32'h0), 100);
        apply(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h4, 32'h0), 101);
        step = 1'b1;
        apply(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h4, 32'h2002_0007), 102);
        step = 1'b0;
        apply(rv(1'b0, 1'b0, 0, 1'b0, 0, 32'h8, 32'h0), 103);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID latch.
- Holds the PC and a word-addressed instruction memory that is loaded before execution.
- Selects the next PC from sequential, branch, jump and stall requests.
- Presents the fetched instruction and PC+4 for the IF/ID latch to capture.
- A small control FSM sequences program load, run and halt.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two, >= 4)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
load_en  input  1  write load_data into imem (IDLE only)
load_addr  input  32  byte address of load write; bits [1:0] ignored
load_data  input  32  instruction word to write
run  input  1  start execution from PC 0 (IDLE only)
stall  input  1  hazard unit: hold PC this cycle
branch_taken  input  1  branch resolved taken; redirect to branch_target
branch_target  input  32  branch destination byte address
jump  input  1  jump decoded; redirect to jump_target
jump_target  input  32  jump destination byte address
pc_out  output  32  current PC
next_pc_out  output  32  pc_out + 4, to IF/ID next_pc_in
instr_out  output  32  fetched instruction, to IF/ID instr_in
halted  output  1  high while in HALTED

Behaviour:
Reset:
- State IDLE; PC = 0; imem contents are not cleared.
- Outputs: pc_out 0, next_pc_out 4, instr_out 0, halted 0.
- Reset overrides every other input in any state, including mid-run and while HALTED.

FSM states: IDLE, RUN, HALTED.
- IDLE:
  - When load_en=1, write imem[load_addr[log2(IMEM_DEPTH)+1:2]] <= load_data.
  - load_addr at or beyond IMEM_DEPTH*4 discards the write.
  - instr_out = 0 (NOP); PC holds at 0.
  - run=1 moves to RUN next cycle. If load_en and run are both high in the same cycle, the write completes and then RUN is entered.
- RUN:
  - instr_out = imem[PC word index], combinational read with zero added latency; the IF/ID latch registers it.
  - PC outside imem range reads 0 (NOP).
  - load_en and run are ignored.
- HALTED:
  - PC frozen; instr_out = 0 so the pipeline drains; halted = 1.
  - Only reset leaves this state.

next_pc_out = pc_out + 4 in all states, modulo 2^32; 32'hFFFF_FFFC wraps to 0.

PC update in RUN, highest priority first:
1. branch_taken -> branch_target. It is older than a jump decoded in ID, so it wins when both are high.
2. jump -> jump_target.
3. stall -> PC holds. A redirect in the same cycle overrides the stall.
4. Fetched word == HALT_WORD -> PC holds, go to HALTED next cycle.
   - instr_out shows HALT_WORD in that cycle so the latch records it.
   - A redirect in the same cycle cancels the halt, because the halt word is on the wrong path.
5. Otherwise PC <= PC + 4 (wraps modulo 2^32).

Target alignment: bits [1:0] of all targets are forced to 0 before loading into the PC.

Optional Feature:
IF_STEP_EN
- When defined:
  - Adds input port step (1 bit).
  - In RUN, the sequential advance (priority 5) and halt detection (priority 4) occur only in cycles with step=1.
  - With step=0 and no redirect, PC holds and instr_out = 0, injecting a bubble; redirects are still accepted.
  - IDLE and HALTED behave the same as without the feature.
- When undefined: no step port; fetch advances every non-stalled cycle as above.

Test Plan:
1. Load imem[0..2] = 0x20010005, 0x20020007, HALT_WORD, pulse run -> pc_out 0,4,8; instr_out 0x20010005, 0x20020007, 0xFFFFFFFF; then halted=1, instr_out=0, pc_out stays 8 for 10+ cycles.
2. In RUN at PC 4, hold stall 3 cycles -> pc_out=4 and instr_out constant all 3 cycles; PC=8 the cycle after stall drops.
3. Same cycle: branch_taken=1 target 0x40, jump=1 target 0x80, stall=1 -> next pc_out=0x40.
4. HALT_WORD at PC 8 with jump=1 target 0x10 that cycle -> no halt, pc_out=0x10, halted=0; misaligned target 0x13 -> pc_out=0x10.
5. Assert reset mid-RUN at PC 0x0C -> next cycle pc_out 0, next_pc_out 4, instr_out 0, state IDLE; imem retained, re-run reproduces scenario 1 sequence.
6. load_en with load_addr=IMEM_DEPTH*4 -> no imem change; in RUN, jump to 0x1000 (beyond depth) -> instr_out=0, PC increments 0x1004; with IF_STEP_EN, step=0 -> PC holds and instr_out=0, step pulse -> PC+4.
